// File: rtl/jk_cmd_sequencer_pkg.sv
// Shared definitions for the JK latch command sequencer: op encodings,
// sequencer states and the latch's ideal next-state function.
package jk_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, SAMPLE} state_t;

  // Q after exactly one enable pulse with {J,K} = op
  function automatic logic next_q(input logic [1:0] op, input logic q);
    case (op)
      OP_HOLD:  return q;
      OP_RESET: return 1'b0;
      OP_SET:   return 1'b1;
      default:  return ~q;
    endcase
  endfunction

endpackage

// File: rtl/jk_cmd_sequencer_if.sv
// Command handshake, latch drive/feedback and response bus of the sequencer.
interface jk_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       J;
  logic       K;
  logic       enable;
  logic       q_in;
  logic       rsp_valid;
  logic [1:0] rsp_op;
  logic       rsp_q;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_op, q_in,
    input  cmd_ready, J, K, enable, rsp_valid, rsp_op, rsp_q, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, q_in,
    output cmd_ready, J, K, enable, rsp_valid, rsp_op, rsp_q, rsp_err
  );
endinterface

// File: rtl/jk_cmd_fifo.sv
// Small synchronous FIFO of 2-bit JK ops with registered occupancy.
module jk_cmd_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [1:0]    i_data,
  input  logic          i_pop,
  output logic [1:0]    o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [LW-1:0] r_level;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd];

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop)  r_rd <= r_rd + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Replays queued JK ops onto a level-sensitive latch as setup/pulse/hold,
// then samples Q and compares it with a resyncing expected-Q model.
module jk_cmd_sequencer
  import jk_pkg::*;
#(
  parameter  int DEPTH        = 4,
  parameter  int PULSE_CYCLES = 2,
  localparam int LW           = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  jk_cmd_sequencer_if.slave   bus,
  output logic                busy,
  output logic [LW-1:0]       level
);

  localparam int PC_EFF = (PULSE_CYCLES < 1) ? 1 : PULSE_CYCLES;
  localparam int CNT_W  = (PC_EFF > 1) ? $clog2(PC_EFF) : 1;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]         r_cur, w_cur_nxt;
  logic               r_j, w_j_nxt;
  logic               r_k, w_k_nxt;
  logic               r_en, w_en_nxt;
  logic               r_rsp_valid, w_rsp_valid_nxt;
  logic [1:0]         r_rsp_op, w_rsp_op_nxt;
  logic               r_rsp_q, w_rsp_q_nxt;
  logic               r_rsp_err, w_rsp_err_nxt;
  logic               r_exp_q, w_exp_nxt;

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [1:0]         w_head;
  logic [LW-1:0]      w_level;

  assign w_push = bus.cmd_valid && !w_full;

  jk_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (bus.cmd_op),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_cur_nxt       = r_cur;
    w_j_nxt         = r_j;
    w_k_nxt         = r_k;
    w_en_nxt        = 1'b0;
    w_pop           = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_op_nxt    = r_rsp_op;
    w_rsp_q_nxt     = r_rsp_q;
    w_rsp_err_nxt   = r_rsp_err;
    w_exp_nxt       = r_exp_q;
    case (r_state)
      // SAMPLE shares the dispatch path so back-to-back ops lose no cycle
      IDLE, SAMPLE: begin
        w_state_nxt = IDLE;
        w_j_nxt     = 1'b0;
        w_k_nxt     = 1'b0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_cur_nxt   = w_head;
          w_j_nxt     = w_head[1];
          w_k_nxt     = w_head[0];
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        w_en_nxt    = 1'b1;
        w_cnt_nxt   = CNT_W'(PC_EFF - 1);
        w_state_nxt = PULSE;
      end
      PULSE: begin
        if (r_cnt == '0) begin
          w_state_nxt = HOLD;
        end else begin
          w_en_nxt  = 1'b1;
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        w_state_nxt     = SAMPLE;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_op_nxt    = r_cur;
        w_rsp_q_nxt     = bus.q_in;
        w_rsp_err_nxt   = (bus.q_in != next_q(r_cur, r_exp_q));
        w_exp_nxt       = bus.q_in;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cur       <= OP_HOLD;
      r_j         <= 1'b0;
      r_k         <= 1'b0;
      r_en        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_op    <= OP_HOLD;
      r_rsp_q     <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_exp_q     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cur       <= w_cur_nxt;
      r_j         <= w_j_nxt;
      r_k         <= w_k_nxt;
      r_en        <= w_en_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_op    <= w_rsp_op_nxt;
      r_rsp_q     <= w_rsp_q_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_exp_q     <= w_exp_nxt;
    end
  end

  assign bus.cmd_ready = !w_full;
  assign bus.J         = r_j;
  assign bus.K         = r_k;
  assign bus.enable    = r_en;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_op    = r_rsp_op;
  assign bus.rsp_q     = r_rsp_q;
  assign bus.rsp_err   = r_rsp_err;
  assign busy          = (r_state != IDLE) || !w_empty;
  assign level         = w_level;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: JK latch model on the pins, timestamp-based
// scoreboard checked every cycle, plus directed literal checks.
module tb_jk_cmd_sequencer;
  import jk_pkg::*;

  localparam int DEPTH = 4;
  localparam int PC    = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jk_cmd_sequencer_if bus ();
  jk_cmd_sequencer_if bus2 ();
  logic          busy, busy2;
  logic [LW-1:0] level;
  logic [1:0]    level2;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .PULSE_CYCLES(PC)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .busy(busy), .level(level)
  );

  jk_cmd_sequencer #(.DEPTH(2), .PULSE_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .busy(busy2), .level(level2)
  );

  // JK characteristic equation, one transition per enable pulse
  function automatic logic jk_ref(input logic j, input logic k, input logic q);
    return (j & ~q) | (~k & q);
  endfunction

  logic latch_q  = 1'b0;
  logic latch2_q = 1'b0;
  logic flt      = 1'b0;
  always @(posedge bus.enable)  latch_q  <= jk_ref(bus.J, bus.K, latch_q);
  always @(posedge bus2.enable) latch2_q <= jk_ref(bus2.J, bus2.K, latch2_q);
  assign bus.q_in  = latch_q & ~flt;
  assign bus2.q_in = latch2_q;

  int n_vec = 0;
  int n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  typedef struct { int e; logic [1:0] op; logic q; logic err; } rsp_t;
  rsp_t rlog[$];
  rsp_t rlog2[$];
  int   en_hi  = 0;
  int   maxlvl = 0;
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1)  rlog.push_back('{ecnt, bus.rsp_op, bus.rsp_q, bus.rsp_err});
    if (bus2.rsp_valid === 1'b1) rlog2.push_back('{ecnt, bus2.rsp_op, bus2.rsp_q, bus2.rsp_err});
    if (bus.enable === 1'b1) en_hi++;
    if (int'(level) > maxlvl) maxlvl = int'(level);
  end

  // Scoreboard: each accepted op gets a start edge and a response edge
  typedef struct { logic [1:0] op; int st; int rs; logic eq; logic eerr; } rec_t;
  rec_t mq[$];
  int   last_rs = -100;
  logic m_latch = 1'b0;
  logic m_rep   = 1'b0;
  bit   armed   = 1'b0;

  always @(negedge clk) begin : model
    int e, lvl, st;
    logic en_x, j_x, k_x, rv_x, rq_x, rerr_x, act;
    logic [1:0] rop_x;
    if (armed) begin
      e = ecnt; lvl = 0; en_x = 0; j_x = 0; k_x = 0; rv_x = 0;
      rq_x = 0; rerr_x = 0; rop_x = 0; act = 0;
      foreach (mq[i]) begin
        if (mq[i].st > e) lvl++;
        if (e >= mq[i].st && e < mq[i].st + PC + 3) begin
          act = 1; j_x = mq[i].op[1]; k_x = mq[i].op[0];
        end
        if (e >= mq[i].st + 1 && e < mq[i].st + 1 + PC) en_x = 1;
        if (e == mq[i].rs) begin
          rv_x = 1; rop_x = mq[i].op; rq_x = mq[i].eq; rerr_x = mq[i].eerr;
        end
      end
      chk("enable", 32'(bus.enable), 32'(en_x));
      chk("J", 32'(bus.J), 32'(j_x));
      chk("K", 32'(bus.K), 32'(k_x));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(rv_x));
      chk("level", 32'(level), lvl);
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(lvl < DEPTH));
      chk("busy", 32'(busy), 32'(act || lvl > 0));
      if (rv_x) begin
        chk("rsp_op", 32'(bus.rsp_op), 32'(rop_x));
        chk("rsp_q", 32'(bus.rsp_q), 32'(rq_x));
        chk("rsp_err", 32'(bus.rsp_err), 32'(rerr_x));
      end
    end
    // events of the coming edge, from inputs that are stable until then
    if (rst) begin
      mq.delete(); last_rs = -100; m_rep = 0; armed = 1;
    end else if (armed) begin
      e = ecnt + 1;
      if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
        st = (e + 1 > last_rs + 1) ? e + 1 : last_rs + 1;
        last_rs = st + PC + 2;
        mq.push_back('{bus.cmd_op, st, last_rs, 1'b0, 1'b0});
      end
      foreach (mq[i]) begin
        if (mq[i].st + 1 == e) m_latch = jk_ref(mq[i].op[1], mq[i].op[0], m_latch);
        if (mq[i].rs == e) begin
          mq[i].eq   = m_latch & ~flt;
          mq[i].eerr = mq[i].eq != jk_ref(mq[i].op[1], mq[i].op[0], m_rep);
          m_rep      = mq[i].eq;
        end
      end
    end
  end

  task automatic push(input logic [1:0] op, output int ae);
    bit rdy;
    ae = -1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); rdy = bus.cmd_ready;
      @(posedge clk); #1;
      if (rdy) begin ae = ecnt; break; end
    end
    if (ae < 0) chk("push_timeout", 0, 1);
  endtask

  task automatic push2(input logic [1:0] op, output int ae);
    bit rdy;
    ae = -1;
    bus2.cmd_valid = 1'b1;
    bus2.cmd_op    = op;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); rdy = bus2.cmd_ready;
      @(posedge clk); #1;
      if (rdy) begin ae = ecnt; break; end
    end
    if (ae < 0) chk("push2_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 200 && rlog.size() < n; i++) begin
      @(posedge clk); #1;
    end
    if (rlog.size() < n) chk("rsp_timeout", rlog.size(), n);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy !== 1'b0; i++) begin
      @(posedge clk); #1;
    end
    if (busy !== 1'b0) chk("idle_timeout", 32'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int a, a2;
    logic [1:0] seq_ops [5];
    logic       seq_q   [5];
    logic [1:0] fill_ops[6];
    int         acc;
    seq_ops  = '{OP_SET, OP_TOGGLE, OP_TOGGLE, OP_RESET, OP_HOLD};
    seq_q    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    fill_ops = '{OP_SET, OP_HOLD, OP_TOGGLE, OP_TOGGLE, OP_RESET, OP_SET};
    bus.cmd_valid = 0;  bus.cmd_op = 0;
    bus2.cmd_valid = 0; bus2.cmd_op = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // reset values
    chk("rst_J", 32'(bus.J), 0);
    chk("rst_K", 32'(bus.K), 0);
    chk("rst_enable", 32'(bus.enable), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_q", 32'(bus.rsp_q), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_rsp_op", 32'(bus.rsp_op), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);

    // single SET
    rlog.delete(); en_hi = 0;
    push(OP_SET, a); bus.cmd_valid = 0;
    @(posedge clk); #1;
    chk("set_setup_J", 32'(bus.J), 1);
    chk("set_setup_K", 32'(bus.K), 0);
    chk("set_setup_en", 32'(bus.enable), 0);
    @(posedge clk); #1;
    chk("set_pulse_en", 32'(bus.enable), 1);
    wait_rsp(1); wait_idle();
    if (rlog.size() >= 1) begin
      chk("set_latency", rlog[0].e - a, 5);
      chk("set_rsp_q", 32'(rlog[0].q), 1);
      chk("set_rsp_err", 32'(rlog[0].err), 0);
      chk("set_rsp_op", 32'(rlog[0].op), 2);
    end
    chk("set_enable_cycles", en_hi, 2);

    // back-to-back sequence
    rlog.delete();
    for (int i = 0; i < 5; i++) push(seq_ops[i], a);
    bus.cmd_valid = 0;
    wait_rsp(5); wait_idle();
    for (int i = 0; i < 5 && i < rlog.size(); i++) begin
      chk("seq_rsp_q", 32'(rlog[i].q), 32'(seq_q[i]));
      chk("seq_rsp_err", 32'(rlog[i].err), 0);
      if (i > 0) chk("seq_spacing", rlog[i].e - rlog[i-1].e, 5);
    end

    // fill: offer 6 ops on consecutive cycles
    rlog.delete(); maxlvl = 0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_valid = 1; bus.cmd_op = fill_ops[i];
      @(negedge clk); if (bus.cmd_ready) acc++;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 0;
    chk("fill_full_ready", 32'(bus.cmd_ready), 0);
    wait_rsp(5); wait_idle();
    chk("fill_accepted", acc, 5);
    chk("fill_max_level", maxlvl, 4);
    chk("fill_rsp_count", rlog.size(), 5);

    // fault injection: Q stuck low across SET and HOLD
    rlog.delete(); flt = 1;
    push(OP_SET, a); push(OP_HOLD, a); bus.cmd_valid = 0;
    wait_rsp(2); flt = 0; wait_idle();
    push(OP_RESET, a); bus.cmd_valid = 0;
    wait_rsp(3); wait_idle();
    if (rlog.size() >= 3) begin
      chk("flt_set_q", 32'(rlog[0].q), 0);
      chk("flt_set_err", 32'(rlog[0].err), 1);
      chk("flt_hold_q", 32'(rlog[1].q), 0);
      chk("flt_hold_err", 32'(rlog[1].err), 0);
      chk("flt_reset_err", 32'(rlog[2].err), 0);
    end

    // reset in the middle of a pulse with three ops queued
    rlog.delete();
    push(OP_SET, a); push(OP_TOGGLE, a); push(OP_TOGGLE, a); push(OP_SET, a);
    bus.cmd_valid = 0;
    for (int i = 0; i < 20 && !(bus.enable === 1'b1 && level == 3); i++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_enable", 32'(bus.enable), 1);
    chk("pre_rst_level", 32'(level), 3);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("midrst_enable", 32'(bus.enable), 0);
    chk("midrst_level", 32'(level), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_cmd_ready", 32'(bus.cmd_ready), 1);
    repeat (15) @(posedge clk);
    #1 chk("midrst_no_rsp", rlog.size(), 0);
    // latch kept Q=1 through reset; expected model restarted at 0
    push(OP_TOGGLE, a); bus.cmd_valid = 0;
    wait_rsp(1); wait_idle();
    push(OP_SET, a); bus.cmd_valid = 0;
    wait_rsp(2); wait_idle();
    if (rlog.size() >= 2) begin
      chk("post_rst_tog_q", 32'(rlog[0].q), 0);
      chk("post_rst_tog_err", 32'(rlog[0].err), 1);
      chk("post_rst_set_q", 32'(rlog[1].q), 1);
      chk("post_rst_set_err", 32'(rlog[1].err), 0);
    end

    // PULSE_CYCLES=1, DEPTH=2 instance
    rlog2.delete();
    push2(OP_SET, a2); push2(OP_TOGGLE, a); bus2.cmd_valid = 0;
    for (int i = 0; i < 60 && rlog2.size() < 2; i++) begin
      @(posedge clk); #1;
    end
    chk("p1_rsp_count", rlog2.size(), 2);
    if (rlog2.size() >= 2) begin
      chk("p1_latency", rlog2[0].e - a2, 4);
      chk("p1_spacing", rlog2[1].e - rlog2[0].e, 4);
      chk("p1_q0", 32'(rlog2[0].q), 1);
      chk("p1_q1", 32'(rlog2[1].q), 0);
      chk("p1_err0", 32'(rlog2[0].err), 0);
      chk("p1_err1", 32'(rlog2[1].err), 0);
    end
    repeat (4) @(posedge clk);
    #1 chk("p1_idle", 32'(busy2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
